// File: rtl/lc3_ctrl_pkg.sv
// Shared types and constants for the LC3 multi-cycle controller: state enum,
// opcode values, memory-access encodings and the opcode path classes.
package lc3_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM_IND,
        S_MEM_READ,
        S_MEM_WRITE,
        S_WRITEBACK,
        S_UPDATE_PC
    } ctrl_state_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LOAD,
        CLS_LOAD_IND,
        CLS_STORE,
        CLS_STORE_IND,
        CLS_CTRL,
        CLS_ILLEGAL
    } op_class_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RES  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    localparam logic [1:0] MEM_IND  = 2'd0;
    localparam logic [1:0] MEM_RD   = 2'd1;
    localparam logic [1:0] MEM_WR   = 2'd2;
    localparam logic [1:0] MEM_IDLE = 2'd3;

    // Branches test the latched nzp mask against the live condition codes;
    // jumps and subroutine calls always redirect the PC.
    function automatic logic branch_decision(input logic [3:0] op,
                                             input logic [2:0] nzp,
                                             input logic [2:0] cc);
        logic taken;
        taken = 1'b0;
        if (op == OP_BR)
            taken = |(nzp & cc);
        else if (op == OP_JMP || op == OP_JSR)
            taken = 1'b1;
        return taken;
    endfunction

endpackage

// File: rtl/lc3_opcode_class.sv
// Combinational opcode-to-path classifier used by the LC3 controller to pick
// which stages an instruction visits.
module lc3_opcode_class
    import lc3_ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [2:0] op_class
);

    op_class_t cls;

    always_comb begin
        cls = CLS_ILLEGAL;
        case (opcode)
            OP_ADD, OP_AND, OP_NOT, OP_LEA: cls = CLS_ALU;
            OP_LD, OP_LDR:                  cls = CLS_LOAD;
            OP_LDI:                         cls = CLS_LOAD_IND;
            OP_ST, OP_STR:                  cls = CLS_STORE;
            OP_STI:                         cls = CLS_STORE_IND;
            OP_BR, OP_JMP, OP_JSR:          cls = CLS_CTRL;
            default:                        cls = CLS_ILLEGAL;
        endcase
    end

    assign op_class = cls;

endmodule

// File: rtl/lc3_controller.sv
// Multi-cycle LC3 sequencer: one stage enable per cycle, Moore outputs.
// Define LC3_CTRL_PERF_EN to build the retired-instruction counter.
module lc3_controller
    import lc3_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] IR,
    input  logic [2:0]  psr,
    input  logic        complete_instr,
    input  logic        complete_data,
    output logic        enable_fetch,
    output logic        enable_decode,
    output logic        enable_execute,
    output logic        enable_writeback,
    output logic        enable_updatePC,
    output logic [1:0]  mem_state,
    output logic        br_taken,
    output logic        illegal_op,
    output logic [31:0] instr_count
);

    ctrl_state_t state;
    ctrl_state_t state_next;
    logic [3:0]  opcode_q;
    logic [2:0]  nzp_q;
    logic [3:0]  class_op;
    logic [2:0]  class_bits;
    op_class_t   op_class;
    logic        unused_ir_bits;

    assign unused_ir_bits = ^IR[8:0];

    // During DECODE the opcode register is not yet loaded, so classify IR directly.
    assign class_op = (state == S_DECODE) ? IR[15:12] : opcode_q;

    lc3_opcode_class u_opcode_class (
        .opcode   (class_op),
        .op_class (class_bits)
    );

    assign op_class = op_class_t'(class_bits);

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:
                if (complete_instr)
                    state_next = S_DECODE;
            S_DECODE:
                state_next = (op_class == CLS_ILLEGAL) ? S_UPDATE_PC : S_EXECUTE;
            S_EXECUTE:
                case (op_class)
                    CLS_ALU:       state_next = S_WRITEBACK;
                    CLS_LOAD:      state_next = S_MEM_READ;
                    CLS_LOAD_IND:  state_next = S_MEM_IND;
                    CLS_STORE:     state_next = S_MEM_WRITE;
                    CLS_STORE_IND: state_next = S_MEM_IND;
                    CLS_CTRL:      state_next = (opcode_q == OP_JSR) ? S_WRITEBACK : S_UPDATE_PC;
                    default:       state_next = S_UPDATE_PC;
                endcase
            S_MEM_IND:
                if (complete_data)
                    state_next = (op_class == CLS_LOAD_IND) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:
                if (complete_data)
                    state_next = S_WRITEBACK;
            S_MEM_WRITE:
                if (complete_data)
                    state_next = S_UPDATE_PC;
            S_WRITEBACK:
                state_next = S_UPDATE_PC;
            S_UPDATE_PC:
                state_next = S_FETCH;
            default:
                state_next = S_FETCH;
        endcase
    end

    // Outputs are registered from the next state so they always match the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= S_FETCH;
            opcode_q         <= 4'd0;
            nzp_q            <= 3'd0;
            enable_fetch     <= 1'b1;
            enable_decode    <= 1'b0;
            enable_execute   <= 1'b0;
            enable_writeback <= 1'b0;
            enable_updatePC  <= 1'b0;
            mem_state        <= MEM_IDLE;
            br_taken         <= 1'b0;
            illegal_op       <= 1'b0;
        end else begin
            state            <= state_next;
            enable_fetch     <= (state_next == S_FETCH);
            enable_decode    <= (state_next == S_DECODE);
            enable_execute   <= (state_next == S_EXECUTE);
            enable_writeback <= (state_next == S_WRITEBACK);
            enable_updatePC  <= (state_next == S_UPDATE_PC);
            case (state_next)
                S_MEM_IND:   mem_state <= MEM_IND;
                S_MEM_READ:  mem_state <= MEM_RD;
                S_MEM_WRITE: mem_state <= MEM_WR;
                default:     mem_state <= MEM_IDLE;
            endcase
            illegal_op <= (state == S_DECODE) && (state_next == S_UPDATE_PC);
            if (state == S_DECODE) begin
                opcode_q <= IR[15:12];
                nzp_q    <= IR[11:9];
                if (state_next == S_UPDATE_PC)
                    br_taken <= 1'b0;
            end
            if (state == S_EXECUTE)
                br_taken <= branch_decision(opcode_q, nzp_q, psr);
        end
    end

`ifdef LC3_CTRL_PERF_EN
    logic [31:0] count_q;

    // Every UPDATE_PC cycle retires one instruction, illegal ones included.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count_q <= 32'd0;
        else if (state == S_UPDATE_PC)
            count_q <= count_q + 32'd1;
    end

    assign instr_count = count_q;
`else
    assign instr_count = 32'd0;
`endif

endmodule

// File: tb/tb_lc3_controller.sv
// Randomized self-checking bench for lc3_controller with an instruction-level
// stage model; honours LC3_CTRL_PERF_EN for the expected instruction count.
module tb_lc3_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] IR;
    logic [2:0]  psr;
    logic        complete_instr;
    logic        complete_data;
    logic        enable_fetch;
    logic        enable_decode;
    logic        enable_execute;
    logic        enable_writeback;
    logic        enable_updatePC;
    logic [1:0]  mem_state;
    logic        br_taken;
    logic        illegal_op;
    logic [31:0] instr_count;

    always #5 clk = ~clk;

    lc3_controller dut (
        .clk              (clk),
        .rst              (rst),
        .IR               (IR),
        .psr              (psr),
        .complete_instr   (complete_instr),
        .complete_data    (complete_data),
        .enable_fetch     (enable_fetch),
        .enable_decode    (enable_decode),
        .enable_execute   (enable_execute),
        .enable_writeback (enable_writeback),
        .enable_updatePC  (enable_updatePC),
        .mem_state        (mem_state),
        .br_taken         (br_taken),
        .illegal_op       (illegal_op),
        .instr_count      (instr_count)
    );

`ifdef LC3_CTRL_PERF_EN
    localparam logic [31:0] PERF_STEP = 32'd1;
`else
    localparam logic [31:0] PERF_STEP = 32'd0;
`endif

    localparam int SG_F  = 0;
    localparam int SG_D  = 1;
    localparam int SG_E  = 2;
    localparam int SG_I  = 3;
    localparam int SG_R  = 4;
    localparam int SG_WR = 5;
    localparam int SG_W  = 6;
    localparam int SG_U  = 7;

    logic [8:0]  expVec;
    logic [31:0] expCount;
    logic        expValid = 1'b0;
    logic        brModel;
    logic [31:0] countModel;
    int          pathBuf[8];
    int          pathLen;

    int cmpTests = 0;
    int cmpFails = 0;
    int litTests = 0;
    int litFails = 0;
    int wbSeen   = 0;
    int exSeen   = 0;
    int illSeen  = 0;

    // Expected output vector {F,D,E,WB,UPC,mem_state,br,illegal} for a stage.
    function automatic logic [8:0] vecFor(input int stg, input logic br, input logic ill);
        logic [1:0] ms;
        ms = (stg == SG_I) ? 2'd0 : (stg == SG_R) ? 2'd1 : (stg == SG_WR) ? 2'd2 : 2'd3;
        return {stg == SG_F, stg == SG_D, stg == SG_E, stg == SG_W, stg == SG_U, ms, br, ill};
    endfunction

    task automatic setPath(input int a, input int b, input int c, input int d,
                           input int e, input int f, input int g, input int n);
        pathBuf[0] = a; pathBuf[1] = b; pathBuf[2] = c; pathBuf[3] = d;
        pathBuf[4] = e; pathBuf[5] = f; pathBuf[6] = g; pathBuf[7] = 0;
        pathLen = n;
    endtask

    // Stage sequence an instruction walks through, straight from the opcode table.
    task automatic buildPath(input logic [3:0] op);
        case (op)
            4'h8, 4'hD, 4'hF:             setPath(SG_F, SG_D, SG_U, 0, 0, 0, 0, 3);
            4'h1, 4'h5, 4'h9, 4'hE, 4'h4: setPath(SG_F, SG_D, SG_E, SG_W, SG_U, 0, 0, 5);
            4'h2, 4'h6:                   setPath(SG_F, SG_D, SG_E, SG_R, SG_W, SG_U, 0, 6);
            4'hA:                         setPath(SG_F, SG_D, SG_E, SG_I, SG_R, SG_W, SG_U, 7);
            4'h3, 4'h7:                   setPath(SG_F, SG_D, SG_E, SG_WR, SG_U, 0, 0, 5);
            4'hB:                         setPath(SG_F, SG_D, SG_E, SG_I, SG_WR, SG_U, 0, 6);
            default:                      setPath(SG_F, SG_D, SG_E, SG_U, 0, 0, 0, 4);
        endcase
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        litTests++;
        if (got !== want) begin
            litFails++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", name, got, want, $time);
        end
    endtask

    // Runs one instruction from its FETCH cycle; starts and ends at posedge+1.
    task automatic applyStimulus(input logic [15:0] ir, input logic [2:0] p, input int fd,
                                 input int md, input int abortAt, output int cycles);
        logic [3:0] op;
        logic       isIllegal;
        int         stg;
        int         reps;
        logic       last;
        op = ir[15:12];
        isIllegal = (op == 4'h8) || (op == 4'hD) || (op == 4'hF);
        IR = ir;
        psr = p;
        buildPath(op);
        cycles = 0;
        for (int s = 0; s < pathLen; s++) begin
            stg = pathBuf[s];
            if (stg == SG_F) reps = 1 + fd;
            else if (stg == SG_I || stg == SG_R || stg == SG_WR) reps = 1 + md;
            else reps = 1;
            for (int r = 0; r < reps; r++) begin
                if (cycles == abortAt) begin
                    expValid = 1'b0;
                    #2 rst = 1'b0;
                    #1;
                    checkOutput("abortFetch", {31'd0, enable_fetch}, 32'd1);
                    checkOutput("abortMemIdle", {30'd0, mem_state}, 32'd3);
                    checkOutput("abortNoWb", {31'd0, enable_writeback}, 32'd0);
                    checkOutput("abortCount", instr_count, 32'd0);
                    brModel = 1'b0;
                    countModel = 32'd0;
                    complete_instr = 1'b0;
                    complete_data = 1'b0;
                    @(negedge clk);
                    rst = 1'b1;
                    @(posedge clk);
                    #1;
                    return;
                end
                last = (r == reps - 1);
                expVec = vecFor(stg, brModel, isIllegal && stg == SG_U);
                expCount = countModel;
                expValid = 1'b1;
                if (stg == SG_F) complete_instr = last;
                else complete_instr = ($urandom_range(0, 1) == 1);
                if (stg == SG_I || stg == SG_R || stg == SG_WR) complete_data = last;
                else complete_data = ($urandom_range(0, 1) == 1);
                @(posedge clk);
                #1;
                cycles++;
                if (stg == SG_E) begin
                    if (op == 4'h0) brModel = |(ir[11:9] & p);
                    else brModel = (op == 4'hC) || (op == 4'h4);
                end
                if (stg == SG_D && isIllegal) brModel = 1'b0;
                if (stg == SG_U) countModel = countModel + PERF_STEP;
            end
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (expValid) begin
            cmpTests++;
            if ({enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC,
                 mem_state, br_taken, illegal_op} !== expVec) begin
                cmpFails++;
                $display("[TB] FAIL cycleOutputs got=%h expected=%h at %0t",
                         {enable_fetch, enable_decode, enable_execute, enable_writeback,
                          enable_updatePC, mem_state, br_taken, illegal_op}, expVec, $time);
            end
            cmpTests++;
            if (instr_count !== expCount) begin
                cmpFails++;
                $display("[TB] FAIL instrCount got=%0d expected=%0d at %0t", instr_count, expCount, $time);
            end
        end
        if (enable_writeback) wbSeen++;
        if (enable_execute) exSeen++;
        if (illegal_op) illSeen++;
    end

    initial begin
        int cyc;
        int snapA;
        int snapB;
        logic [3:0]  op;
        logic [15:0] ir;
        rst = 1'b0;
        IR = 16'h0000;
        psr = 3'b000;
        complete_instr = 1'b0;
        complete_data = 1'b0;
        brModel = 1'b0;
        countModel = 32'd0;
        #12;
        checkOutput("resetVector", {23'd0, enable_fetch, enable_decode, enable_execute,
                    enable_writeback, enable_updatePC, mem_state, br_taken, illegal_op}, 32'h10C);
        checkOutput("resetCount", instr_count, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(16'h1283, 3'b000, 0, 0, -1, cyc);
        checkOutput("addCycles", cyc, 32'd5);
        applyStimulus(16'hA201, 3'b000, 0, 2, -1, cyc);
        checkOutput("ldiCycles", cyc, 32'd11);
        applyStimulus(16'h0405, 3'b010, 0, 0, -1, cyc);
        checkOutput("brzCycles", cyc, 32'd4);
        checkOutput("brzTaken", {31'd0, br_taken}, 32'd1);
        applyStimulus(16'h0405, 3'b001, 0, 0, -1, cyc);
        checkOutput("brzNotTaken", {31'd0, br_taken}, 32'd0);
        snapA = wbSeen;
        applyStimulus(16'hB000, 3'b000, 0, 0, -1, cyc);
        checkOutput("stiCycles", cyc, 32'd6);
        checkOutput("stiNoWriteback", wbSeen - snapA, 32'd0);
        snapA = exSeen;
        snapB = illSeen;
        applyStimulus(16'hF025, 3'b000, 0, 0, -1, cyc);
        checkOutput("trapCycles", cyc, 32'd3);
        checkOutput("trapNoExecute", exSeen - snapA, 32'd0);
        checkOutput("trapIllegalPulse", illSeen - snapB, 32'd1);

        applyStimulus(16'h2000, 3'b000, 0, 3, 4, cyc);
        applyStimulus(16'h1283, 3'b000, 0, 0, -1, cyc);
        applyStimulus(16'h5283, 3'b000, 1, 0, -1, cyc);
        applyStimulus(16'h1000, 3'b000, 0, 0, -1, cyc);
        checkOutput("countAfter3Add", instr_count, 32'd3 * PERF_STEP);

        for (int n = 0; n < 400; n++) begin
            op = 4'($urandom_range(0, 15));
            ir = {op, 12'($urandom)};
            applyStimulus(ir, 3'($urandom_range(0, 7)), $urandom_range(0, 3),
                          $urandom_range(0, 3), -1, cyc);
        end

        expValid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", cmpTests + litTests, cmpFails + litFails);
        $finish;
    end

endmodule
